branch_select_ctrl: RTL and testbench

- Next-PC sequencer for the single-cycle CPU; produces the 4-bit `Selection` code consumed by `Mux_BranchSelect`.
- Owns the PC register and latches the mux `Output` (wired back as `NextPC`) every unstalled cycle.
- Owns exception/interrupt sequencing: saved return address (`EPC`), handler mode, sticky double-fault state.
- Vector addresses (22 IRQ, 12 trap, 200 fault) live in the mux; this block only selects them.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_cond_eval.sv | 22 ++
 rtl/branch_select_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_select_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants and types for the next-PC sequencer
package branch_pkg;

  localparam int BP_ADDR_W = 17;

  localparam logic [2:0] BR_SEQ  = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_JMP  = 3'd4;
  localparam logic [2:0] BR_JR   = 3'd5;
  localparam logic [2:0] BR_RETI = 3'd6;
  localparam logic [2:0] BR_TRAP = 3'd7;

  localparam logic [3:0] SEL_PC1   = 4'd0;
  localparam logic [3:0] SEL_TGT   = 4'd1;
  localparam logic [3:0] SEL_REG   = 4'd2;
  localparam logic [3:0] SEL_EPC   = 4'd3;
  localparam logic [3:0] SEL_IRQ   = 4'd4;
  localparam logic [3:0] SEL_TRAP  = 4'd5;
  localparam logic [3:0] SEL_FAULT = 4'd6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - resolves whether a branch/jump opcode redirects to its target
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] i_branch_op,
  input  logic       i_zero,
  input  logic       i_negative,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_branch_op)
      BR_BEQ:  o_taken = i_zero;
      BR_BNE:  o_taken = ~i_zero;
      BR_BLT:  o_taken = i_negative;
      BR_JMP:  o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_select_ctrl.sv
// rtl/branch_select_ctrl.sv - next-PC select sequencer with PC/EPC registers and IRQ/trap/fault FSM
module branch_select_ctrl
  import branch_pkg::*;
#(
  parameter int                ADDR_W   = BP_ADDR_W,
  parameter int                SEL_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic [2:0]        BranchOp,
  input  logic              Zero,
  input  logic              Negative,
  input  logic              IrqReq,
  input  logic [ADDR_W-1:0] NextPC,
  output logic [SEL_W-1:0]  Selection,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] EPC,
  output logic              InHandler,
  output logic              Faulted,
  output logic              IrqAck
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  state_e            r_state;
  logic              r_irq_pending;
  logic              r_in_handler;
  logic              r_faulted;

  logic              w_taken;
  logic [3:0]        w_sel;
  state_e            w_state_nxt;
  logic              w_take_irq;
  logic              w_epc_load;
  logic [ADDR_W-1:0] w_pc_inc;

  branch_cond_eval u_cond (
    .i_branch_op (BranchOp),
    .i_zero      (Zero),
    .i_negative  (Negative),
    .o_taken     (w_taken)
  );

  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_sel       = SEL_PC1;
    w_state_nxt = r_state;
    w_take_irq  = 1'b0;
    w_epc_load  = 1'b0;

    // Normal decode first; state-specific events below override it.
    case (BranchOp)
      BR_BEQ, BR_BNE, BR_BLT, BR_JMP: w_sel = w_taken ? SEL_TGT : SEL_PC1;
      BR_JR:                          w_sel = SEL_REG;
      default:                        w_sel = SEL_PC1;
    endcase

    case (r_state)
      ST_RUN: begin
        if (BranchOp == BR_TRAP) begin
          w_sel       = SEL_TRAP;
          w_epc_load  = 1'b1;
          w_state_nxt = ST_HANDLER;
        end else if (BranchOp == BR_SEQ && (r_irq_pending || IrqReq)) begin
          w_sel       = SEL_IRQ;
          w_epc_load  = 1'b1;
          w_take_irq  = 1'b1;
          w_state_nxt = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (BranchOp == BR_TRAP) begin
          w_sel       = SEL_FAULT;
          w_state_nxt = ST_FAULT;
        end else if (BranchOp == BR_RETI) begin
          w_sel       = SEL_EPC;
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (BranchOp == BR_TRAP) begin
          w_sel = SEL_FAULT;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc          <= RESET_PC;
      r_epc         <= '0;
      r_state       <= ST_RUN;
      r_irq_pending <= 1'b0;
      r_in_handler  <= 1'b0;
      r_faulted     <= 1'b0;
    end else begin
      if (!Stall) begin
        r_pc         <= NextPC;
        r_state      <= w_state_nxt;
        r_in_handler <= (w_state_nxt != ST_RUN);
        r_faulted    <= (w_state_nxt == ST_FAULT);
        if (w_epc_load) begin
          r_epc <= w_pc_inc;
        end
      end
      // Pending latches even while stalled so a single-cycle pulse survives.
      if (w_take_irq && !Stall) begin
        r_irq_pending <= 1'b0;
      end else begin
        r_irq_pending <= r_irq_pending | IrqReq;
      end
    end
  end

  assign Selection = SEL_W'(w_sel);
  assign PC        = r_pc;
  assign EPC       = r_epc;
  assign InHandler = r_in_handler;
  assign Faulted   = r_faulted;
  assign IrqAck    = w_take_irq & ~Stall;

endmodule

// File: tb/tb_branch_select_ctrl.sv
// tb/tb_branch_select_ctrl.sv - self-checking bench for branch_select_ctrl
module tb_branch_select_ctrl;

  localparam int AW = 17;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;
  localparam logic [2:0] OP_JR   = 3'd5;
  localparam logic [2:0] OP_RETI = 3'd6;
  localparam logic [2:0] OP_TRAP = 3'd7;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Stall;
  logic [2:0]    BranchOp;
  logic          Zero;
  logic          Negative;
  logic          IrqReq;
  logic [AW-1:0] NextPC;
  logic [3:0]    Selection;
  logic [AW-1:0] PC;
  logic [AW-1:0] EPC;
  logic          InHandler;
  logic          Faulted;
  logic          IrqAck;

  logic [AW-1:0] r_tgt;
  logic [AW-1:0] r_reg;

  typedef struct packed {
    logic [3:0] sel;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  branch_select_ctrl dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Stall     (Stall),
    .BranchOp  (BranchOp),
    .Zero      (Zero),
    .Negative  (Negative),
    .IrqReq    (IrqReq),
    .NextPC    (NextPC),
    .Selection (Selection),
    .PC        (PC),
    .EPC       (EPC),
    .InHandler (InHandler),
    .Faulted   (Faulted),
    .IrqAck    (IrqAck)
  );

  always #5 Clock = ~Clock;

  // External mux model: vectors 22 IRQ, 12 trap, 200 fault.
  always_comb begin
    case (Selection)
      4'd1:    NextPC = r_tgt;
      4'd2:    NextPC = r_reg;
      4'd3:    NextPC = EPC;
      4'd4:    NextPC = 17'd22;
      4'd5:    NextPC = 17'd12;
      4'd6:    NextPC = 17'd200;
      default: NextPC = PC + 17'd1;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one cycle starting at posedge+1; compares at the negedge, returns at posedge+1.
  task automatic step(input logic [2:0] op, input logic z, input logic n,
                      input logic irq, input logic stl,
                      input logic [3:0] es, input logic ea, input string nm);
    exp_t e;
    BranchOp = op;
    Zero     = z;
    Negative = n;
    IrqReq   = irq;
    Stall    = stl;
    exp_q.push_back('{sel: es, ack: ea});
    @(negedge Clock);
    e = exp_q.pop_front();
    checks++;
    if (Selection !== e.sel) begin
      errors++;
      $display("FAIL %s sel: got %0d expected %0d", nm, Selection, e.sel);
    end
    checks++;
    if (IrqAck !== e.ack) begin
      errors++;
      $display("FAIL %s ack: got %0b expected %0b", nm, IrqAck, e.ack);
    end
    @(posedge Clock);
    #1;
    IrqReq = 1'b0;
    Stall  = 1'b0;
  endtask

  task automatic check_state(input logic [AW-1:0] pc, input logic [AW-1:0] epc,
                             input logic inh, input logic flt, input string nm);
    checks++;
    if (PC !== pc || EPC !== epc || InHandler !== inh || Faulted !== flt) begin
      errors++;
      $display("FAIL %s state: got pc=%h epc=%h inh=%b flt=%b expected pc=%h epc=%h inh=%b flt=%b",
               nm, PC, EPC, InHandler, Faulted, pc, epc, inh, flt);
    end
  endtask

  task automatic do_reset(input logic stl);
    Reset = 1'b1;
    Stall = stl;
    BranchOp = OP_TRAP;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    Stall = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    check_state(17'd0, 17'd0, 1'b0, 1'b0, "reset");
    step(OP_SEQ, 0, 0, 0, 0, 4'd0, 1'b0, "reset_seq");
    check_state(17'd1, 17'd0, 1'b0, 1'b0, "reset_seq_pc");
  endtask

  task automatic test_reset_from_fault;
    step(OP_TRAP, 0, 0, 0, 0, 4'd5, 1'b0, "rf_trap");
    check_state(17'd12, 17'd2, 1'b1, 1'b0, "rf_handler");
    step(OP_TRAP, 0, 0, 0, 0, 4'd6, 1'b0, "rf_trap2");
    r_tgt = 17'h00055;
    step(OP_JMP, 0, 0, 1, 0, 4'd1, 1'b0, "rf_jmp_irq");
    check_state(17'h00055, 17'd2, 1'b1, 1'b1, "rf_fault");
    do_reset(1'b1);
    check_state(17'd0, 17'd0, 1'b0, 1'b0, "rf_reset");
    step(OP_SEQ, 0, 0, 0, 0, 4'd0, 1'b0, "rf_seq_no_pending");
  endtask

  task automatic test_branches;
    r_tgt = 17'd10;
    r_reg = 17'h00300;
    step(OP_JMP, 0, 0, 0, 0, 4'd1, 1'b0, "br_jmp");
    check_state(17'd10, 17'd0, 1'b0, 1'b0, "br_pc10");
    step(OP_BEQ, 1, 0, 0, 0, 4'd1, 1'b0, "br_beq_t");
    step(OP_BEQ, 0, 0, 0, 0, 4'd0, 1'b0, "br_beq_nt");
    check_state(17'd11, 17'd0, 1'b0, 1'b0, "br_pc11");
    step(OP_BNE, 0, 0, 0, 0, 4'd1, 1'b0, "br_bne_t");
    step(OP_BNE, 1, 0, 0, 0, 4'd0, 1'b0, "br_bne_nt");
    step(OP_BLT, 0, 1, 0, 0, 4'd1, 1'b0, "br_blt_t");
    step(OP_BLT, 0, 0, 0, 0, 4'd0, 1'b0, "br_blt_nt");
    step(OP_JR, 0, 0, 0, 0, 4'd2, 1'b0, "br_jr");
    step(OP_RETI, 0, 0, 0, 0, 4'd0, 1'b0, "br_reti_run");
    check_state(17'h00301, 17'd0, 1'b0, 1'b0, "br_end");
  endtask

  task automatic test_irq;
    r_tgt = 17'd40;
    step(OP_JMP, 0, 0, 0, 0, 4'd1, 1'b0, "irq_to40");
    r_tgt = 17'd77;
    step(OP_JMP, 0, 0, 1, 0, 4'd1, 1'b0, "irq_defer_jmp");
    check_state(17'd77, 17'd0, 1'b0, 1'b0, "irq_deferred");
    step(OP_SEQ, 0, 0, 0, 0, 4'd4, 1'b1, "irq_take");
    check_state(17'd22, 17'd78, 1'b1, 1'b0, "irq_handler");
    step(OP_SEQ, 0, 0, 0, 0, 4'd0, 1'b0, "irq_hseq");
    step(OP_RETI, 0, 0, 0, 0, 4'd3, 1'b0, "irq_reti");
    check_state(17'd78, 17'd78, 1'b0, 1'b0, "irq_back");
    step(OP_SEQ, 0, 0, 0, 0, 4'd0, 1'b0, "irq_cleared");
  endtask

  task automatic test_trap_fault;
    r_tgt = 17'd100;
    step(OP_JMP, 0, 0, 0, 0, 4'd1, 1'b0, "tf_to100");
    step(OP_TRAP, 0, 0, 0, 0, 4'd5, 1'b0, "tf_trap");
    check_state(17'd12, 17'd101, 1'b1, 1'b0, "tf_handler");
    step(OP_TRAP, 0, 0, 0, 0, 4'd6, 1'b0, "tf_double");
    check_state(17'd200, 17'd101, 1'b1, 1'b1, "tf_fault");
    step(OP_RETI, 0, 0, 0, 0, 4'd0, 1'b0, "tf_reti");
    check_state(17'd201, 17'd101, 1'b1, 1'b1, "tf_sticky");
    step(OP_SEQ, 0, 0, 1, 0, 4'd0, 1'b0, "tf_irq_blocked");
    step(OP_TRAP, 0, 0, 0, 0, 4'd6, 1'b0, "tf_trap_again");
    step(OP_SEQ, 0, 0, 0, 0, 4'd0, 1'b0, "tf_still_blocked");
  endtask

  task automatic test_wrap;
    do_reset(1'b0);
    r_tgt = 17'h1FFFF;
    step(OP_JMP, 0, 0, 0, 0, 4'd1, 1'b0, "wr_jmp");
    step(OP_SEQ, 0, 0, 1, 0, 4'd4, 1'b1, "wr_irq");
    check_state(17'd22, 17'd0, 1'b1, 1'b0, "wr_epc0");
    step(OP_RETI, 0, 0, 0, 0, 4'd3, 1'b0, "wr_reti");
    check_state(17'd0, 17'd0, 1'b0, 1'b0, "wr_pc0");
  endtask

  task automatic test_stall;
    step(OP_TRAP, 0, 0, 0, 0, 4'd5, 1'b0, "st_trap");
    check_state(17'd12, 17'd1, 1'b1, 1'b0, "st_handler");
    step(OP_SEQ, 0, 0, 1, 1, 4'd0, 1'b0, "st_stall_irq");
    check_state(17'd12, 17'd1, 1'b1, 1'b0, "st_hold");
    step(OP_RETI, 0, 0, 0, 0, 4'd3, 1'b0, "st_reti");
    check_state(17'd1, 17'd1, 1'b0, 1'b0, "st_run");
    step(OP_SEQ, 0, 0, 0, 0, 4'd4, 1'b1, "st_take");
    check_state(17'd22, 17'd2, 1'b1, 1'b0, "st_taken");
  endtask

  task automatic test_back_to_back;
    step(OP_RETI, 0, 0, 0, 0, 4'd3, 1'b0, "bb_reti");
    check_state(17'd2, 17'd2, 1'b0, 1'b0, "bb_run");
    step(OP_SEQ, 0, 0, 1, 1, 4'd4, 1'b0, "bb_stalled_take");
    check_state(17'd2, 17'd2, 1'b0, 1'b0, "bb_hold");
    step(OP_SEQ, 0, 0, 0, 0, 4'd4, 1'b1, "bb_take");
    check_state(17'd22, 17'd3, 1'b1, 1'b0, "bb_handler");
    step(OP_TRAP, 0, 0, 0, 1, 4'd6, 1'b0, "bb_stalled_trap");
    check_state(17'd22, 17'd3, 1'b1, 1'b0, "bb_no_fault");
  endtask

  initial begin
    Reset    = 1'b1;
    Stall    = 1'b0;
    BranchOp = OP_SEQ;
    Zero     = 1'b0;
    Negative = 1'b0;
    IrqReq   = 1'b0;
    r_tgt    = '0;
    r_reg    = '0;
    @(posedge Clock);
    #1;
    test_reset();
    test_reset_from_fault();
    test_branches();
    test_irq();
    test_trap_fault();
    test_wrap();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
